axi_read_responder: RTL

- Memory-side AXI read responder: the slave end of the read-address/read-data channels driven by the instruction and data caches during line refills.
- Accepts one burst request at a time and returns ARLEN words from a word-addressed backing RAM, with a programmable first-beat latency.
- Includes a preload port so benches and boot logic can fill the RAM.
- Used as the refill memory model in simulation and as on-chip boot memory on FPGA.

---
 rtl/axi_read_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
//
// Memory-side AXI read responder used as the refill memory for the instruction
// and data caches (simulation model) and as on-chip boot memory (FPGA).
// It accepts one incrementing burst at a time. After a fixed LATENCY of idle
// cycles it streams the requested words from a word-addressed RAM. A preload
// port fills the RAM while the responder is idle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ARADDR/ARLEN/ARID   burst byte address, beat count (0 means 16), request ID
//   ARVALID/ARREADY     read-address handshake
//   RDATA/RID/RLAST     beat data, burst ID, final-beat flag
//   RVALID/RREADY       read-data handshake
//   load_en/load_addr/load_data   preload write port, honoured only when idle
//   load_ready          high when a preload write is accepted (idle state)
// -----------------------------------------------------------------------------
module axi_read_responder #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 14,
  parameter int ID_WIDTH   = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ID_WIDTH-1:0]   RID,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  load_en,
  input  logic [MEM_AW-1:0]     load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // The counter holds LATENCY-1 so that WAIT lasts exactly LATENCY cycles.
  localparam logic [7:0] WAIT_INIT = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [4:0]            beats_q, beats_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            wait_q, wait_d;

  logic                  rd_en;
  logic [MEM_AW-1:0]     rd_addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic [MEM_AW-1:0]     req_waddr;
  logic                  last;

  assign req_waddr = ARADDR[MEM_AW+1:2];
  assign last      = (beats_q == 5'd1);
  assign wr_en     = load_en && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping carries no reset: it is always reloaded on acceptance.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    beats_q <= beats_d;
    id_q    <= id_d;
    wait_q  <= wait_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    id_d    = id_q;
    wait_d  = wait_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (ARVALID) begin
          addr_d  = req_waddr;
          beats_d = (ARLEN == 4'd0) ? 5'd16 : {1'b0, ARLEN};
          id_d    = ARID;
          wait_d  = WAIT_INIT;
          if (LATENCY == 0) begin
            state_d = S_BURST;
            rd_en   = 1'b1;
            rd_addr = req_waddr;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 8'd0) begin
          state_d = S_BURST;
          rd_en   = 1'b1;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_BURST: begin
        if (RREADY) begin
          if (last) begin
            state_d = S_IDLE;
          end else begin
            // The next beat is fetched only on a handshake, so the output
            // register holds steady through RREADY stalls.
            addr_d  = addr_q + MEM_AW'(1);
            beats_d = beats_q - 5'd1;
            rd_en   = 1'b1;
            rd_addr = addr_q + MEM_AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Forward a same-cycle preload so a burst accepted together with the
  // write (zero latency) still sees the new word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_q <= (wr_en && (load_addr == rd_addr)) ? load_data : mem[rd_addr];
    end
  end

  assign ARREADY    = (state_q == S_IDLE);
  assign load_ready = (state_q == S_IDLE);
  assign RVALID     = (state_q == S_BURST);
  assign RLAST      = RVALID && last;
  assign RDATA      = RVALID ? rdata_q : '0;
  assign RID        = RVALID ? id_q : '0;

endmodule
